ascii_cmd_assembler: RTL
========================

Name: ascii_cmd_assembler

Overview:
Host-side front end that builds the 16-bit command words consumed by the command decoders (Cmd_In/Cmd_En, upper 12 bits = command code, lower 4 bits = value).
Takes a byte stream of ASCII hex characters, e.g. from the UART receiver, and packs NUM_CHARS hex digits MSB-first into one command word.
Presents the word with a one-cycle Cmd_En strobe.
This is the inverse direction of Hex_2_ASCII; it rejects malformed or stalled words.

Parameters:
NUM_CHARS, 4, hex digits per command word; CMD_W = 4*NUM_CHARS (16 at default).
TIMEOUT_CYCLES, 40000, idle Clk_In cycles allowed between digits of a partial word; counter width = clog2(TIMEOUT_CYCLES+1).

Ports:
Clk_In     input   1        system clock, all logic on rising edge
Rst        input   1        asynchronous, active-high reset
Rx_Data    input   [8:1]    ASCII byte, sampled only when Rx_Valid=1
Rx_Valid   input   1        one-cycle byte strobe; no backpressure, a byte may arrive every cycle
Cmd_Out    output  [CMD_W:1] assembled command word, held until next completed word
Cmd_En     output  1        one-cycle pulse, Cmd_Out valid in the same cycle
Cmd_Err    output  1        one-cycle pulse, partial word discarded
Busy       output  1        1 while a partial word is held (digit count != 0)

Behaviour:
- Reset (async, Rst=1): Cmd_Out=0, Cmd_En=0, Cmd_Err=0, Busy=0, shift register=0, digit count=0, timeout counter=0. State is IDLE.
- Character classes:
  - HEX: '0'-'9' (0x30-0x39) ->0-9; 'A'-'F' (0x41-0x46) ->A-F; 'a'-'f' (0x61-0x66) ->A-F.
  - SEP: 0x0D, 0x0A, 0x20.
  - BAD: everything else.
- States: IDLE (count=0) and COLLECT (0<count<NUM_CHARS). Busy = (state==COLLECT).
- IDLE:
  - HEX -> shift={shift,nibble}, count=1, go to COLLECT, timeout counter cleared.
  - SEP -> ignored.
  - BAD -> Cmd_Err pulse next cycle, stay in IDLE.
- COLLECT, Rx_Valid with HEX and count<NUM_CHARS-1 -> shift in nibble, count+1, timeout counter cleared.
- COLLECT, Rx_Valid with HEX and count==NUM_CHARS-1 (final digit):
  - Cmd_Out <= {shift[CMD_W-4:1], nibble} and Cmd_En=1 on the next rising edge; latency is 1 cycle from the final-digit sample.
  - count=0, go to IDLE in the same edge, so a byte on the very next cycle starts a new word with no gap.
- COLLECT, Rx_Valid with SEP or BAD -> partial discarded, count=0, IDLE, Cmd_Err pulse. A mid-word separator is an error.
- COLLECT, no Rx_Valid -> timeout counter increments. When it reaches TIMEOUT_CYCLES: discard partial, count=0, IDLE, Cmd_Err pulse, counter cleared.
- A Rx_Valid in the same cycle the counter would hit TIMEOUT_CYCLES takes priority; the byte is processed normally and no timeout occurs.
- Cmd_En and Cmd_Err are never asserted in the same cycle, and neither is asserted for more than 1 cycle per event.
- Cmd_Out changes only with Cmd_En. Errors never alter Cmd_Out.
- Shift register need not be cleared on discard; only count governs validity. Stale bits must never reach Cmd_Out, because a full NUM_CHARS digits always overwrite it.
- Reset asserted mid-word: async clear as above. No Cmd_En or Cmd_Err is produced for the aborted word.

Test Plan:
1. Reset, then bytes "E123" on 4 consecutive cycles -> exactly one Cmd_En, 1 cycle after '3', with Cmd_Out=16'hE123. Busy=1 from after 'E' until the '3' edge. Cmd_Err never set.
2. "d12a", CR, LF, "D122" with random 0-5 cycle gaps -> Cmd_En twice: Cmd_Out=16'hD12A, then 16'hD122. CR/LF produce no Cmd_Err.
3. "D1G2" then "D122" -> Cmd_Err pulse 1 cycle after 'G'. The trailing '2' starts a new word, so the following "D12" completes it as 16'h2D12 with one Cmd_En. Cmd_Out is unchanged before that.
4. Timeout with TIMEOUT_CYCLES=16: "D1", then 16 idle cycles -> Cmd_Err at the timeout and Busy drops. Then "E123" -> Cmd_Out=16'hE123, not 16'hD1E1.
5. Boundary timeout with TIMEOUT_CYCLES=16: "D1", 15 idle cycles, then "22" -> no error, Cmd_Out=16'hD122.
6. Reset pulse after "E1" -> Busy=0 and Cmd_Out=0 immediately (asynchronously), no pulses. Then "0000" -> Cmd_En with Cmd_Out=16'h0000.

Source files
------------

// File: rtl/ascii_cmd_assembler_if.sv
// Byte-stream input and command-word output bundle for ascii_cmd_assembler.
// The master drives ASCII bytes in; the slave returns assembled command words and status.
interface ascii_cmd_assembler_if #(
  parameter int NUM_CHARS = 4
);
  localparam int CMD_W = 4 * NUM_CHARS;

  logic [8:1]     Rx_Data;
  logic           Rx_Valid;
  logic [CMD_W:1] Cmd_Out;
  logic           Cmd_En;
  logic           Cmd_Err;
  logic           Busy;

  modport master (
    output Rx_Data, Rx_Valid,
    input  Cmd_Out, Cmd_En, Cmd_Err, Busy
  );

  modport slave (
    input  Rx_Data, Rx_Valid,
    output Cmd_Out, Cmd_En, Cmd_Err, Busy
  );
endinterface

// File: rtl/ascii_cmd_assembler.sv
// Packs NUM_CHARS ASCII hex digits (MSB first) into one command word with a Cmd_En strobe.
// Malformed characters, mid-word separators and stalled partial words raise a Cmd_Err pulse.
module ascii_cmd_assembler #(
  parameter int NUM_CHARS      = 4,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input logic               Clk_In,
  input logic               Rst,
  ascii_cmd_assembler_if.slave bus
);
  localparam int CMD_W = 4 * NUM_CHARS;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW    = $clog2(NUM_CHARS + 1);

  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_CHARS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  // state | meaning
  // IDLE    | no partial word held (count == 0)
  // COLLECT | 0 < count < NUM_CHARS digits held
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_COLLECT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CMD_W-4:1] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    to_q, to_d;
  logic [CMD_W:1]   cmd_out_q, cmd_out_d;
  logic             cmd_en_q, cmd_en_d;
  logic             cmd_err_q, cmd_err_d;

  logic       is_hex;
  logic       is_sep;
  logic [3:0] nib;

  always_comb begin
    is_hex = 1'b0;
    is_sep = 1'b0;
    nib    = 4'h0;
    if (bus.Rx_Data >= 8'h30 && bus.Rx_Data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = bus.Rx_Data[4:1];
    end else if ((bus.Rx_Data >= 8'h41 && bus.Rx_Data <= 8'h46) ||
                 (bus.Rx_Data >= 8'h61 && bus.Rx_Data <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so adding 9 yields 0xA.
      is_hex = 1'b1;
      nib    = bus.Rx_Data[4:1] + 4'd9;
    end else if (bus.Rx_Data == 8'h0D || bus.Rx_Data == 8'h0A || bus.Rx_Data == 8'h20) begin
      is_sep = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    cmd_out_d = cmd_out_q;
    cmd_en_d  = 1'b0;
    cmd_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Rx_Valid) begin
          if (is_hex) begin
            shift_d = (CMD_W-4)'({shift_q, nib});
            cnt_d   = CW'(1);
            to_d    = '0;
            state_d = S_COLLECT;
          end else if (!is_sep) begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (bus.Rx_Valid) begin
          to_d = '0;
          if (is_hex && cnt_q == LAST_CNT) begin
            cmd_out_d = {shift_q, nib};
            cmd_en_d  = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else if (is_hex) begin
            shift_d = (CMD_W-4)'({shift_q, nib});
            cnt_d   = cnt_q + CW'(1);
          end else begin
            cmd_err_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end
        end else if (to_q == TO_LAST) begin
          // The idle cycle that would reach TIMEOUT_CYCLES abandons the word.
          cmd_err_d = 1'b1;
          cnt_d     = '0;
          to_d      = '0;
          state_d   = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        to_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk_In or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      cmd_out_q <= '0;
      cmd_en_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      cmd_out_q <= cmd_out_d;
      cmd_en_q  <= cmd_en_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign bus.Cmd_Out = cmd_out_q;
  assign bus.Cmd_En  = cmd_en_q;
  assign bus.Cmd_Err = cmd_err_q;
  assign bus.Busy    = (state_q == S_COLLECT);
endmodule
